// File: rtl/irq_pending_if.sv
// Handshake and status bundle between the interrupt pending controller and the core's trap logic.
interface irq_pending_if;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] pending;
   logic [7:0] mask;

   modport master (
      output irq_valid, irq_id, pending, mask,
      input  irq_ack, mask_we, mask_wdata
   );

   modport slave (
      input  irq_valid, irq_id, pending, mask,
      output irq_ack, mask_we, mask_wdata
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Eight-channel interrupt pending/mask register with a stable highest-index-wins
// presentation under a valid/ack handshake.
module irq_pending_ctrl #(
   parameter logic [7:0] EDGE_MASK = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_in,
   irq_pending_if.master bus
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t     state_q;
   logic       valid_q;
   logic [2:0] id_q;
   logic [7:0] irq_q, irq_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] set_term;
   logic [7:0] clr_term;
   logic [7:0] effective;

   // Highest set index wins, matching the codebase's 8-to-3 encoder.
   function automatic logic [2:0] prio_enc(input logic [7:0] v);
      prio_enc = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) prio_enc = i[2:0];
      end
   endfunction

   always_comb begin
      irq_d     = irq_in;
      set_term  = (irq_in & ~irq_q & EDGE_MASK) | (irq_in & ~EDGE_MASK);
      clr_term  = (bus.irq_ack && valid_q) ? (8'h01 << id_q) : 8'h00;
      // Set is ORed in after the clear so a same-cycle new request survives the ack.
      pending_d = set_term | (pending_q & ~clr_term);
      mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
      effective = pending_q & mask_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q     <= 8'h00;
         pending_q <= 8'h00;
         mask_q    <= 8'h00;
      end else begin
         irq_q     <= irq_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   // Once presenting, the ID is frozen until ack: no preemption, no withdrawal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         id_q    <= 3'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|effective) begin
                  id_q    <= prio_enc(effective);
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.irq_ack) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.irq_valid = valid_q;
   assign bus.irq_id    = id_q;
   assign bus.pending   = pending_q;
   assign bus.mask      = mask_q;

endmodule
